// File: rtl/touch_pio_in_irq.sv
// Avalon-MM input PIO for touch-panel and button lines.
// Each pin is synchronised and then debounced. Edges of the filtered level are latched
// in a write-1-to-clear capture register, and a per-bit mask gates them onto a level irq.
module touch_pio_in_irq #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // A one-bit counter is still needed when DEBOUNCE_CYCLES is 1; it simply never counts.
  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [WIDTH-1:0]                  stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
  logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
  logic [31:0]                       readdata_q, readdata_d;
  logic [WIDTH-1:0]                  synced;
  logic [WIDTH-1:0]                  edge_evt;
  logic                              wr_en;
  logic                              unused_wd;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Shift pins through the synchroniser chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Accept a new level only after it has differed from the filtered level for
  // DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (synced[b] == stable_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CntMax) begin
        stable_d[b] = synced[b];
        cnt_d[b]    = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  // Select the edge polarity that counts as an event.
  always_comb begin
    stable_dly_d = stable_q;
    if (EDGE_TYPE == 0) begin
      edge_evt = stable_q & ~stable_dly_q;
    end else if (EDGE_TYPE == 1) begin
      edge_evt = ~stable_q & stable_dly_q;
    end else begin
      edge_evt = stable_q ^ stable_dly_q;
    end
  end

  // Register writes: mask load and write-1-to-clear capture, where a new event beats a clear.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (address == 2'd2)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == 2'd3)) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_evt;
  end

  // Read mux, loaded every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  // State registers, all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      edgecap_q    <= '0;
      irqmask_q    <= '0;
      readdata_q   <= '0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      edgecap_q    <= edgecap_d;
      irqmask_q    <= irqmask_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_touch_pio_in_irq.sv
// Directed bench for touch_pio_in_irq with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, rising edges.
module tb_touch_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  touch_pio_in_irq #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push the expected word, present the address for one edge, then pop and compare.
  task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    address = addr;
    tick(1);
    chk(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // 1. Reset and idle with all pins high.
    tick(3);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset   = 1'b0;
    address = 2'd0;
    tick(5);
    do_read(2'd0, 32'h0, "data_before_latency");  // stable rises at edge 6, read sees old
    do_read(2'd0, 32'hF, "data_after_latency");
    do_read(2'd3, 32'hF, "edgecap_from_reset");
    chk("idle_irq_masked", {31'b0, irq}, 32'h0);

    // 2. Glitch reject, then an accepted 4-cycle pulse on bit 1.
    in_port = 4'h0;
    tick(8);
    do_write(2'd3, 32'hF);
    do_read(2'd3, 32'h0, "edgecap_cleared");
    in_port = 4'b0010;
    tick(3);
    in_port = 4'h0;
    tick(10);
    do_read(2'd0, 32'h0, "glitch_data");
    do_read(2'd3, 32'h0, "glitch_edgecap");
    chk("glitch_irq", {31'b0, irq}, 32'h0);
    in_port = 4'b0010;
    tick(4);
    in_port = 4'h0;
    tick(12);
    do_read(2'd3, 32'h2, "pulse4_edgecap");

    // 3. Mask bit 2; a bit-0 capture must not raise irq, a bit-2 capture must.
    do_write(2'd3, 32'hF);
    do_write(2'd2, 32'hFFFF_FFF4);  // upper writedata bits are dropped
    do_read(2'd2, 32'h4, "irqmask_rd");
    in_port = 4'b0001;
    tick(8);
    do_read(2'd3, 32'h1, "edgecap_bit0");
    chk("irq_bit0_masked_out", {31'b0, irq}, 32'h0);
    in_port = 4'b0101;
    tick(8);
    do_read(2'd3, 32'h5, "edgecap_bit0_2");
    chk("irq_bit2", {31'b0, irq}, 32'h1);

    // 4. Write-1-to-clear.
    do_write(2'd3, 32'h1);
    chk("irq_after_w1c_bit0", {31'b0, irq}, 32'h1);
    do_read(2'd3, 32'h4, "edgecap_after_w1c_bit0");
    do_write(2'd3, 32'h4);
    chk("irq_after_w1c_bit2", {31'b0, irq}, 32'h0);
    do_read(2'd3, 32'h0, "edgecap_after_w1c_bit2");

    // 5. Clear of bit 3 on the same edge as its capture: set wins.
    do_write(2'd2, 32'h8);
    in_port = 4'b1101;  // pin change lands before edge k+1
    tick(6);            // stable[3] rises at edge k+6
    chk("irq_before_capture", {31'b0, irq}, 32'h0);
    do_write(2'd3, 32'h8);  // clear sampled at edge k+7 with the capture
    chk("irq_set_wins", {31'b0, irq}, 32'h1);
    do_read(2'd3, 32'h8, "edgecap_set_wins");

    // 6. Reset while irq is high and bit 1 is mid-debounce (counter at 2).
    in_port = 4'b0111;
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_irq_drop", {31'b0, irq}, 32'h0);
    chk("async_readdata_clear", readdata, 32'h0);
    tick(2);
    reset = 1'b0;
    do_read(2'd2, 32'h0, "post_rst_irqmask");
    do_read(2'd3, 32'h0, "post_rst_edgecap");
    address = 2'd0;
    tick(3);
    do_read(2'd0, 32'h0, "post_rst_data_early");
    do_read(2'd0, 32'h7, "post_rst_data_full");
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/touch_pio_in_irq.md
Name: touch_pio_in_irq

Overview:
- Parametrised Avalon-MM input PIO for touch-panel and button lines on the Nios II system.
- Generalises the single-bit, always-readable input port:
  - WIDTH input bits.
  - Metastability synchroniser on every bit.
  - Per-bit debounce filter.
  - Edge-capture register with write-1-to-clear.
  - Per-bit interrupt mask driving a level irq to the CPU.
- Sits between the board pins and the system interconnect.

Parameters:
- WIDTH, 1, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flop count (≥2).
- DEBOUNCE_CYCLES, 1, consecutive clk cycles a synchronised level must differ from the filtered level before it is accepted (≥1; 1 = no filtering).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous pin inputs.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - reset asserts asynchronously and is released synchronously by the system.
  - All flops clear to 0 on reset: sync chain, debounce counters, filtered level `stable`, `stable_d`, edgecapture, irqmask, readdata. irq = 0.
- Synchroniser:
  - in_port passes through SYNC_STAGES flops to give `synced`.
  - A pin change present before edge 0 appears on `synced` after edge SYNC_STAGES.
- Debounce (per bit, counter of width clog2(DEBOUNCE_CYCLES)):
  - If synced == stable: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable ← synced and counter ← 0.
  - Else: counter ← counter+1.
  - A pulse on `synced` shorter than DEBOUNCE_CYCLES cycles never reaches `stable`.
  - Pin-to-stable latency = SYNC_STAGES + DEBOUNCE_CYCLES edges.
- Edge detect:
  - stable_d ← stable every cycle.
  - Event per bit:
    - rising = stable & ~stable_d
    - falling = ~stable & stable_d
    - any = stable ^ stable_d
  - The 0→0 state after reset produces no event.
- edgecapture[WIDTH-1:0]:
  - Bit sets at the edge following its event.
  - Write to address 3 (chipselect=1, write_n=0) clears every bit where writedata bit = 1.
  - Event and clear on the same bit in the same cycle: set wins.
  - Bits written 0 are unchanged.
- irqmask[WIDTH-1:0]: loaded from writedata[WIDTH-1:0] on a write to address 2.
- irq = |(edgecapture & irqmask), combinational from registers.
  - irq rises in the same cycle edgecapture sets, if the bit is masked in.
  - Unmasking an already-captured bit raises irq the cycle after the mask write.
- Register map, readdata loaded every clk edge from the address mux regardless of chipselect (read latency 1), upper bits zero:
  - 0: stable (data).
  - 1: 0 (reserved, direction).
  - 2: irqmask.
  - 3: edgecapture.
- Writes to addresses 0 and 1 are ignored. writedata bits ≥ WIDTH are ignored.
- Reset mid-debounce or with irq high: all state clears immediately and irq drops asynchronously.

Test Plan:
Bench configuration: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0.
1. Reset and idle: assert reset with in_port=4'hF, then release → readdata=0 and irq=0 during reset. After release, address 0 reads 4'hF from the 6th edge after release (2 sync + 4 debounce). edgecapture=4'hF (rising edges from 0).
2. Glitch reject: in_port[1] 0→1 for 3 cycles then back to 0 → data bit 1 stays 0, edgecapture bit 1 stays 0, irq=0. Repeat with a 4-cycle pulse → bit 1 sets in edgecapture.
3. Mask and irq: write address 2 = 4'b0100, then in_port[2] rising edge → edgecapture=4'b0100 and irq=1. A rising edge on bit 0 sets edgecapture bit 0 but irq depends only on bit 2.
4. W1C: edgecapture=4'b0101, write address 3 = 4'b0001 → edgecapture=4'b0100 next cycle and irq stays 1. Write 4'b0100 → edgecapture=0 and irq=0.
5. Simultaneous set and clear: time a W1C of bit 3 to the same edge as a bit-3 event → bit 3 remains 1 and irq stays asserted if masked.
6. Reset mid-operation: reset asserted with irq=1 and a debounce counter at 2 → irq drops without a clock. After release all registers read 0, and the counter restarts from 0 (full 4 cycles required).
